fft_4_point: RTL and testbench



---
 rtl/fft_4_point.sv | 204 ++++++++++++++++++++
 tb/tb_fft_4_point.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_4_point.sv
// fft_4_point
//   Fully pipelined 4-point radix-2 decimation-in-time FFT on complex
//   two's-complement 16.16 fixed-point samples. Twiddles are only 1 and -j,
//   so both butterfly stages are pure add/subtract. Results are full-scale
//   (unscaled) sums, saturated to the signed DATA_W range on output.
//
//   Pipeline (one transform accepted per clock):
//     E0 : start=1 captures x0..x3
//     E1 : stage-1 butterflies a=x0+x2, b=x0-x2, c=x1+x3, d=x1-x3
//     E2 : stage-2 combine + saturation into y0..y3, done pulses
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous reset, active-high (wins over start)
//   start                one-cycle strobe, samples x* on the same edge
//   xN_real / xN_imag    time-domain samples x[N], DATA_W bits each
//   yK_real / yK_imag    frequency bins Y[K], registered, held until next result
//   done                 one-cycle pulse, y* valid from this cycle onward

module fft_4_point #(
    parameter int DATA_W  = 32,
    parameter int GUARD_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] x0_real,
    input  logic [DATA_W-1:0] x0_imag,
    input  logic [DATA_W-1:0] x1_real,
    input  logic [DATA_W-1:0] x1_imag,
    input  logic [DATA_W-1:0] x2_real,
    input  logic [DATA_W-1:0] x2_imag,
    input  logic [DATA_W-1:0] x3_real,
    input  logic [DATA_W-1:0] x3_imag,
    output logic [DATA_W-1:0] y0_real,
    output logic [DATA_W-1:0] y0_imag,
    output logic [DATA_W-1:0] y1_real,
    output logic [DATA_W-1:0] y1_imag,
    output logic [DATA_W-1:0] y2_real,
    output logic [DATA_W-1:0] y2_imag,
    output logic [DATA_W-1:0] y3_real,
    output logic [DATA_W-1:0] y3_imag,
    output logic              done
);

    localparam int EXT_W = DATA_W + GUARD_W;

    // Sign-extend a sample into the guarded internal width.
    function automatic logic [EXT_W-1:0] sx(input logic [DATA_W-1:0] w);
        return {{GUARD_W{w[DATA_W-1]}}, w};
    endfunction

    // Clamp a guarded value to the signed DATA_W range. The value fits when
    // the guard bits and the output sign bit all agree.
    function automatic logic [DATA_W-1:0] sat(input logic [EXT_W-1:0] v);
        logic [GUARD_W:0] top;
        top = v[EXT_W-1:DATA_W-1];
        if ((top == '0) || (top == '1)) begin
            return v[DATA_W-1:0];
        end else if (v[EXT_W-1]) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    // ------------------------------------------------------------------
    // Stage 0: input capture
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] xr_q [4];
    logic [DATA_W-1:0] xi_q [4];
    logic [DATA_W-1:0] xr_d [4];
    logic [DATA_W-1:0] xi_d [4];
    logic              valid0_q;
    logic              valid0_d;

    always_comb begin
        xr_d     = xr_q;
        xi_d     = xi_q;
        valid0_d = start;
        if (start) begin
            xr_d[0] = x0_real;
            xi_d[0] = x0_imag;
            xr_d[1] = x1_real;
            xi_d[1] = x1_imag;
            xr_d[2] = x2_real;
            xi_d[2] = x2_imag;
            xr_d[3] = x3_real;
            xi_d[3] = x3_imag;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: first butterfly layer (even/odd pairs x0/x2 and x1/x3)
    // ------------------------------------------------------------------
    logic [EXT_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic [EXT_W-1:0] c_re_q, c_im_q, d_re_q, d_im_q;
    logic [EXT_W-1:0] a_re_d, a_im_d, b_re_d, b_im_d;
    logic [EXT_W-1:0] c_re_d, c_im_d, d_re_d, d_im_d;
    logic             valid1_q;
    logic             valid1_d;

    always_comb begin
        a_re_d   = a_re_q;
        a_im_d   = a_im_q;
        b_re_d   = b_re_q;
        b_im_d   = b_im_q;
        c_re_d   = c_re_q;
        c_im_d   = c_im_q;
        d_re_d   = d_re_q;
        d_im_d   = d_im_q;
        valid1_d = valid0_q;
        if (valid0_q) begin
            a_re_d = sx(xr_q[0]) + sx(xr_q[2]);
            a_im_d = sx(xi_q[0]) + sx(xi_q[2]);
            b_re_d = sx(xr_q[0]) - sx(xr_q[2]);
            b_im_d = sx(xi_q[0]) - sx(xi_q[2]);
            c_re_d = sx(xr_q[1]) + sx(xr_q[3]);
            c_im_d = sx(xi_q[1]) + sx(xi_q[3]);
            d_re_d = sx(xr_q[1]) - sx(xr_q[3]);
            d_im_d = sx(xi_q[1]) - sx(xi_q[3]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: second butterfly layer + saturation
    //   Y1 = b - j*d : -j*(dr + j*di) = di - j*dr
    //   Y3 = b + j*d :  j*(dr + j*di) = -di + j*dr
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] yr_q [4];
    logic [DATA_W-1:0] yi_q [4];
    logic [DATA_W-1:0] yr_d [4];
    logic [DATA_W-1:0] yi_d [4];
    logic              done_q;
    logic              done_d;

    always_comb begin
        yr_d   = yr_q;
        yi_d   = yi_q;
        done_d = valid1_q;
        if (valid1_q) begin
            yr_d[0] = sat(a_re_q + c_re_q);
            yi_d[0] = sat(a_im_q + c_im_q);
            yr_d[1] = sat(b_re_q + d_im_q);
            yi_d[1] = sat(b_im_q - d_re_q);
            yr_d[2] = sat(a_re_q - c_re_q);
            yi_d[2] = sat(a_im_q - c_im_q);
            yr_d[3] = sat(b_re_q - d_im_q);
            yi_d[3] = sat(b_im_q + d_re_q);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
                yr_q[i] <= '0;
                yi_q[i] <= '0;
            end
            valid0_q <= 1'b0;
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            c_re_q   <= '0;
            c_im_q   <= '0;
            d_re_q   <= '0;
            d_im_q   <= '0;
            valid1_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            xr_q     <= xr_d;
            xi_q     <= xi_d;
            valid0_q <= valid0_d;
            a_re_q   <= a_re_d;
            a_im_q   <= a_im_d;
            b_re_q   <= b_re_d;
            b_im_q   <= b_im_d;
            c_re_q   <= c_re_d;
            c_im_q   <= c_im_d;
            d_re_q   <= d_re_d;
            d_im_q   <= d_im_d;
            valid1_q <= valid1_d;
            yr_q     <= yr_d;
            yi_q     <= yi_d;
            done_q   <= done_d;
        end
    end

    assign y0_real = yr_q[0];
    assign y0_imag = yi_q[0];
    assign y1_real = yr_q[1];
    assign y1_imag = yi_q[1];
    assign y2_real = yr_q[2];
    assign y2_imag = yi_q[2];
    assign y3_real = yr_q[3];
    assign y3_imag = yi_q[3];
    assign done    = done_q;

endmodule

// File: tb/tb_fft_4_point.sv
// tb_fft_4_point
//   Self-checking bench for fft_4_point. Directed vectors carry hand-derived
//   expected bins; randomized streams are checked against a direct DFT
//   reference (sum of x[n] * (-j)^(n*k)) computed with 64-bit integers and
//   clamped to the 32-bit signed range.

module tb_fft_4_point;

    typedef struct packed {
        logic [3:0][31:0] r;
        logic [3:0][31:0] i;
    } bins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] xr [4];
    logic [31:0] xi [4];
    logic [31:0] y0_real, y0_imag, y1_real, y1_imag;
    logic [31:0] y2_real, y2_imag, y3_real, y3_imag;
    logic        done;

    int unsigned checks = 0;
    int unsigned passed = 0;
    bins_t       last_exp;

    always #5 clk = ~clk;

    fft_4_point #(
        .DATA_W (32),
        .GUARD_W(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x0_real(xr[0]),
        .x0_imag(xi[0]),
        .x1_real(xr[1]),
        .x1_imag(xi[1]),
        .x2_real(xr[2]),
        .x2_imag(xi[2]),
        .x3_real(xr[3]),
        .x3_imag(xi[3]),
        .y0_real(y0_real),
        .y0_imag(y0_imag),
        .y1_real(y1_real),
        .y1_imag(y1_imag),
        .y2_real(y2_real),
        .y2_imag(y2_imag),
        .y3_real(y3_real),
        .y3_imag(y3_imag),
        .done   (done)
    );

    // ---------------- helpers (stimulus / model only) ----------------

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bins_t observed();
        bins_t b;
        b.r[0] = y0_real; b.i[0] = y0_imag;
        b.r[1] = y1_real; b.i[1] = y1_imag;
        b.r[2] = y2_real; b.i[2] = y2_imag;
        b.r[3] = y3_real; b.i[3] = y3_imag;
        return b;
    endfunction

    function automatic bins_t mk(input logic [31:0] r0, i0, r1, i1, r2, i2, r3, i3);
        bins_t b;
        b.r[0] = r0; b.i[0] = i0;
        b.r[1] = r1; b.i[1] = i1;
        b.r[2] = r2; b.i[2] = i2;
        b.r[3] = r3; b.i[3] = i3;
        return b;
    endfunction

    function automatic logic [31:0] clamp(input longint v);
        if (v > 64'sd2147483647) return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return v[31:0];
    endfunction

    // Direct DFT with W = exp(-j*2*pi/4) = -j.
    function automatic bins_t model();
        bins_t  b;
        longint sr, si, a, c;
        for (int k = 0; k < 4; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                a = longint'($signed(xr[n]));
                c = longint'($signed(xi[n]));
                case ((n * k) % 4)
                    0: begin sr += a; si += c; end   // * 1
                    1: begin sr += c; si -= a; end   // * -j
                    2: begin sr -= a; si -= c; end   // * -1
                    default: begin sr -= c; si += a; end // * j
                endcase
            end
            b.r[k] = clamp(sr);
            b.i[k] = clamp(si);
        end
        return b;
    endfunction

    function automatic logic [31:0] rnd_word();
        int s;
        case ($urandom_range(0, 2))
            0: return $urandom;
            1: begin
                s = int'($urandom_range(0, 32'h000FFFFF)) - 32'h00080000;
                return 32'(s);
            end
            default: begin
                case ($urandom_range(0, 2))
                    0: return 32'h7FFFFFFF;
                    1: return 32'h80000000;
                    default: return 32'h00000000;
                endcase
            end
        endcase
    endfunction

    task automatic set_rand();
        for (int n = 0; n < 4; n++) begin
            xr[n] = rnd_word();
            xi[n] = rnd_word();
        end
    endtask

    task automatic set_x(input logic [31:0] r0, r1, r2, r3, i0, i1, i2, i3);
        xr[0] = r0; xr[1] = r1; xr[2] = r2; xr[3] = r3;
        xi[0] = i0; xi[1] = i1; xi[2] = i2; xi[3] = i3;
    endtask

    // One start strobe, then advance to the cycle after E2.
    task automatic fire();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        bins_t o;
        rst   = 1'b1;
        start = 1'b0;
        set_x('0, '0, '0, '0, '0, '0, '0, '0);
        step();
        step();
        checks++;
        if (done === 1'b0) passed++;
        else $display("FAIL reset_done: got %b want 0", done);
        o = observed();
        checks++;
        if (o === bins_t'(0)) passed++;
        else $display("FAIL reset_bins: got %h want 0", o);
        rst = 1'b0;
        step();
        last_exp = '0;
    endtask

    task automatic test_dc();
        bins_t e, o;
        e = mk(32'h00040000, 0, 0, 0, 0, 0, 0, 0);
        set_x(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 0, 0, 0, 0);
        start = 1'b1;
        step();                       // E0
        start = 1'b0;
        checks++;
        if (done === 1'b0) passed++;
        else $display("FAIL dc_done_e0: got %b want 0", done);
        step();                       // E1
        checks++;
        if (done === 1'b0) passed++;
        else $display("FAIL dc_done_e1: got %b want 0", done);
        step();                       // E2
        checks++;
        if (done === 1'b1) passed++;
        else $display("FAIL dc_done_e2: got %b want 1", done);
        o = observed();
        checks++;
        if (o === e) passed++;
        else $display("FAIL dc_bins: got %h want %h", o, e);
        step();
        checks++;
        if (done === 1'b0) passed++;
        else $display("FAIL dc_done_fall: got %b want 0", done);
        step();
        o = observed();
        checks++;
        if (o === e) passed++;
        else $display("FAIL dc_hold: got %h want %h", o, e);
        last_exp = e;
    endtask

    task automatic test_impulse();
        bins_t e, o;
        e = mk(32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0);
        set_x(32'h00010000, 0, 0, 0, 0, 0, 0, 0);
        fire();
        checks++;
        if (done === 1'b1) passed++;
        else $display("FAIL impulse_done: got %b want 1", done);
        o = observed();
        checks++;
        if (o === e) passed++;
        else $display("FAIL impulse_bins: got %h want %h", o, e);
        last_exp = e;
    endtask

    task automatic test_x1_only();
        bins_t e, o;
        e = mk(32'h00010000, 0, 0, 32'hFFFF0000, 32'hFFFF0000, 0, 0, 32'h00010000);
        set_x(0, 32'h00010000, 0, 0, 0, 0, 0, 0);
        fire();
        checks++;
        if (done === 1'b1) passed++;
        else $display("FAIL x1_done: got %b want 1", done);
        o = observed();
        checks++;
        if (o === e) passed++;
        else $display("FAIL x1_bins: got %h want %h", o, e);
        last_exp = e;
    endtask

    task automatic test_saturation();
        bins_t e, o;
        e = mk(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 0, 0, 0);
        set_x(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
              32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
        fire();
        o = observed();
        checks++;
        if (o === e) passed++;
        else $display("FAIL sat_bins: got %h want %h", o, e);
        last_exp = e;
    endtask

    task automatic test_back_to_back();
        bins_t e1, e2, o;
        e1 = mk(32'h00040000, 0, 0, 0, 0, 0, 0, 0);
        e2 = mk(32'h00010000, 0, 0, 32'hFFFF0000, 32'hFFFF0000, 0, 0, 32'h00010000);
        set_x(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 0, 0, 0, 0);
        start = 1'b1;
        step();
        set_x(0, 32'h00010000, 0, 0, 0, 0, 0, 0);
        step();
        start = 1'b0;
        set_x('0, '0, '0, '0, '0, '0, '0, '0);
        checks++;
        if (done === 1'b0) passed++;
        else $display("FAIL b2b_done_early: got %b want 0", done);
        step();
        o = observed();
        checks++;
        if (done === 1'b1 && o === e1) passed++;
        else $display("FAIL b2b_first: done %b bins %h want 1 %h", done, o, e1);
        step();
        o = observed();
        checks++;
        if (done === 1'b1 && o === e2) passed++;
        else $display("FAIL b2b_second: done %b bins %h want 1 %h", done, o, e2);
        step();
        o = observed();
        checks++;
        if (done === 1'b0 && o === e2) passed++;
        else $display("FAIL b2b_after: done %b bins %h want 0 %h", done, o, e2);
        last_exp = e2;
    endtask

    task automatic test_reset_mid();
        bins_t e, o;
        int unsigned seen;
        // Reset the cycle after start: transform is discarded.
        set_x(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 0, 0, 0, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        rst   = 1'b1;
        step();
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (done !== 1'b0) seen++;
            step();
        end
        checks++;
        if (seen == 0) passed++;
        else $display("FAIL rstmid_done: got %0d pulses want 0", seen);
        o = observed();
        checks++;
        if (o === bins_t'(0)) passed++;
        else $display("FAIL rstmid_bins: got %h want 0", o);
        // Reset and start on the same edge: reset wins.
        set_x(0, 32'h00010000, 0, 0, 0, 0, 0, 0);
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        seen  = 0;
        for (int c = 0; c < 3; c++) begin
            if (done !== 1'b0) seen++;
            step();
        end
        o = observed();
        checks++;
        if (seen == 0 && o === bins_t'(0)) passed++;
        else $display("FAIL rst_wins: pulses %0d bins %h want 0 0", seen, o);
        // Normal operation afterwards.
        e = mk(32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0);
        set_x(32'h00010000, 0, 0, 0, 0, 0, 0, 0);
        fire();
        o = observed();
        checks++;
        if (done === 1'b1 && o === e) passed++;
        else $display("FAIL rstmid_recover: done %b bins %h want 1 %h", done, o, e);
        last_exp = e;
    endtask

    task automatic test_no_start_hold();
        bins_t o;
        int unsigned bad;
        bad = 0;
        step();
        for (int c = 0; c < 5; c++) begin
            set_rand();
            step();
            o = observed();
            if (done !== 1'b0 || o !== last_exp) bad++;
        end
        checks++;
        if (bad == 0) passed++;
        else $display("FAIL no_start_hold: got %0d bad cycles want 0, bins %h want %h",
                      bad, observed(), last_exp);
    endtask

    task automatic test_random_stream();
        bins_t q[$];
        bins_t o, e;
        logic  s, s1, s2, exp_done;
        s1 = 1'b0;
        s2 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            s = (c < 60) && ($urandom_range(0, 3) != 0);
            set_rand();
            if (s) q.push_back(model());
            start = s;
            step();
            exp_done = s2;
            s2 = s1;
            s1 = s;
            o = observed();
            checks++;
            if (done !== exp_done) begin
                $display("FAIL rand_done c%0d: got %b want %b", c, done, exp_done);
            end else if (exp_done) begin
                e = (q.size() > 0) ? q.pop_front() : last_exp;
                last_exp = e;
                if (o === e) passed++;
                else $display("FAIL rand_bins c%0d: got %h want %h", c, o, e);
            end else begin
                if (o === last_exp) passed++;
                else $display("FAIL rand_hold c%0d: got %h want %h", c, o, last_exp);
            end
        end
        start = 1'b0;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL rand_drain: got %0d pending want 0", q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_x1_only();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_no_start_hold();
        test_random_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
